exu_regfile_sb: RTL and testbench

Parametrised integer register file with a built-in scoreboard for the EXU. It provides two combinational read ports, two independent writeback ports and optional same-cycle writeback-to-read bypass. A per-register busy bit is set at instruction issue and cleared at writeback, which lets the dispatch stage stall on RAW and WAW hazards without a separate hazard unit. It sits between the decode/dispatch stage and the ALU/long-pipe writeback arbiters.

---
 rtl/exu_regfile_sb_if.sv | 37 +++
 rtl/exu_regfile_sb.sv | 81 ++++++++
 tb/tb_exu_regfile_sb.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/exu_regfile_sb_if.sv
// exu_regfile_sb_if: read, issue and writeback bus between dispatch/writeback and the register file
interface exu_regfile_sb_if #(
    parameter int XLEN        = 32,
    parameter int RFIDX_WIDTH = 5
);
    logic [RFIDX_WIDTH-1:0] read_src1_idx;
    logic [RFIDX_WIDTH-1:0] read_src2_idx;
    logic [XLEN-1:0]        read_src1_dat;
    logic [XLEN-1:0]        read_src2_dat;
    logic                   read_src1_busy;
    logic                   read_src2_busy;
    logic                   iss_vld;
    logic                   iss_rdy;
    logic                   iss_rdwen;
    logic [RFIDX_WIDTH-1:0] iss_rdidx;
    logic                   iss_rs1en;
    logic                   iss_rs2en;
    logic                   wbck0_wen;
    logic [RFIDX_WIDTH-1:0] wbck0_idx;
    logic [XLEN-1:0]        wbck0_dat;
    logic                   wbck1_wen;
    logic [RFIDX_WIDTH-1:0] wbck1_idx;
    logic [XLEN-1:0]        wbck1_dat;
    logic [XLEN-1:0]        x1_r;

    modport master (
        output read_src1_idx, read_src2_idx, iss_vld, iss_rdwen, iss_rdidx, iss_rs1en, iss_rs2en,
               wbck0_wen, wbck0_idx, wbck0_dat, wbck1_wen, wbck1_idx, wbck1_dat,
        input  read_src1_dat, read_src2_dat, read_src1_busy, read_src2_busy, iss_rdy, x1_r
    );

    modport slave (
        input  read_src1_idx, read_src2_idx, iss_vld, iss_rdwen, iss_rdidx, iss_rs1en, iss_rs2en,
               wbck0_wen, wbck0_idx, wbck0_dat, wbck1_wen, wbck1_idx, wbck1_dat,
        output read_src1_dat, read_src2_dat, read_src1_busy, read_src2_busy, iss_rdy, x1_r
    );
endinterface

// File: rtl/exu_regfile_sb.sv
// exu_regfile_sb: integer register file with per-register busy scoreboard and optional writeback bypass
module exu_regfile_sb #(
    parameter int XLEN        = 32,
    parameter int RFREG_NUM   = 32,
    parameter int RFIDX_WIDTH = 5,
    parameter bit BYPASS      = 1'b1
) (
    input logic              clk,
    input logic              rst,
    exu_regfile_sb_if.slave  bus
);
    // Storage covers every encodable index; slots that are x0 or beyond RFREG_NUM are never
    // written, so they stay at their reset value of zero and read back as zero for free.
    localparam int NSLOT = 1 << RFIDX_WIDTH;

    typedef logic [RFIDX_WIDTH-1:0] idx_t;

    function automatic logic [NSLOT-1:0] live_mask();
        logic [NSLOT-1:0] m;
        for (int i = 0; i < NSLOT; i++) m[i] = (i != 0) && (i < RFREG_NUM);
        return m;
    endfunction

    localparam logic [NSLOT-1:0] LIVE = live_mask();

    logic [XLEN-1:0]  rf_q    [NSLOT];
    logic [XLEN-1:0]  rf_d    [NSLOT];
    logic [XLEN-1:0]  byp_dat [NSLOT];
    logic [NSLOT-1:0] busy_q;
    logic [NSLOT-1:0] busy_d;
    logic [NSLOT-1:0] busy_eff;
    logic [NSLOT-1:0] wb0_hit;
    logic [NSLOT-1:0] wb1_hit;
    logic [NSLOT-1:0] iss_set;
    logic             iss_fire;

    // Per-register writeback decode and the bypass-adjusted view seen by the read/issue side
    always_comb begin
        for (int i = 0; i < NSLOT; i++) begin
            wb0_hit[i]  = LIVE[i] && bus.wbck0_wen && (bus.wbck0_idx == idx_t'(i));
            wb1_hit[i]  = LIVE[i] && bus.wbck1_wen && (bus.wbck1_idx == idx_t'(i));
            byp_dat[i]  = (BYPASS && wb1_hit[i]) ? bus.wbck1_dat :
                          (BYPASS && wb0_hit[i]) ? bus.wbck0_dat : rf_q[i];
            busy_eff[i] = busy_q[i] && !(BYPASS && (wb0_hit[i] || wb1_hit[i]));
        end
    end

    // Read ports, issue readiness and the issue strobe
    always_comb begin
        bus.read_src1_dat  = byp_dat[bus.read_src1_idx];
        bus.read_src2_dat  = byp_dat[bus.read_src2_idx];
        bus.read_src1_busy = busy_eff[bus.read_src1_idx];
        bus.read_src2_busy = busy_eff[bus.read_src2_idx];
        bus.iss_rdy        = !(bus.iss_rs1en && busy_eff[bus.read_src1_idx]) &&
                             !(bus.iss_rs2en && busy_eff[bus.read_src2_idx]) &&
                             !(bus.iss_rdwen && busy_eff[bus.iss_rdidx]);
        iss_fire           = bus.iss_vld && bus.iss_rdy;
    end

    assign bus.x1_r = rf_q[1];

    // Next state: port 1 data wins a same-index conflict; a new issue outranks a same-cycle clear
    always_comb begin
        for (int i = 0; i < NSLOT; i++) begin
            iss_set[i] = LIVE[i] && iss_fire && bus.iss_rdwen && (bus.iss_rdidx == idx_t'(i));
            rf_d[i]    = wb1_hit[i] ? bus.wbck1_dat : wb0_hit[i] ? bus.wbck0_dat : rf_q[i];
            busy_d[i]  = iss_set[i] || (busy_q[i] && !(wb0_hit[i] || wb1_hit[i]));
        end
    end

    // Register and scoreboard state, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_q   <= '{default: '0};
            busy_q <= '0;
        end else begin
            rf_q   <= rf_d;
            busy_q <= busy_d;
        end
    end
endmodule

// File: tb/tb_exu_regfile_sb.sv
// tb_exu_regfile_sb: directed and randomized checks of both bypass variants against a behavioural model
module tb_exu_regfile_sb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  s1, s2, rd, i0, i1;
    logic [31:0] d0, d1;
    logic        w0, w1, vld, rs1en, rs2en, rdwen;
    int          checks = 0;
    int          errors = 0;

    // Architectural model: one register array, one busy array per bypass variant
    logic [31:0] m_rf [32];
    bit          m_bsy [2][32];

    exu_regfile_sb_if #(.XLEN(32), .RFIDX_WIDTH(5)) b1 ();
    exu_regfile_sb_if #(.XLEN(32), .RFIDX_WIDTH(5)) b0 ();

    assign b1.read_src1_idx = s1;    assign b0.read_src1_idx = s1;
    assign b1.read_src2_idx = s2;    assign b0.read_src2_idx = s2;
    assign b1.iss_vld       = vld;   assign b0.iss_vld       = vld;
    assign b1.iss_rdwen     = rdwen; assign b0.iss_rdwen     = rdwen;
    assign b1.iss_rdidx     = rd;    assign b0.iss_rdidx     = rd;
    assign b1.iss_rs1en     = rs1en; assign b0.iss_rs1en     = rs1en;
    assign b1.iss_rs2en     = rs2en; assign b0.iss_rs2en     = rs2en;
    assign b1.wbck0_wen     = w0;    assign b0.wbck0_wen     = w0;
    assign b1.wbck0_idx     = i0;    assign b0.wbck0_idx     = i0;
    assign b1.wbck0_dat     = d0;    assign b0.wbck0_dat     = d0;
    assign b1.wbck1_wen     = w1;    assign b0.wbck1_wen     = w1;
    assign b1.wbck1_idx     = i1;    assign b0.wbck1_idx     = i1;
    assign b1.wbck1_dat     = d1;    assign b0.wbck1_dat     = d1;

    exu_regfile_sb #(.XLEN(32), .RFREG_NUM(32), .RFIDX_WIDTH(5), .BYPASS(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(b1)
    );
    exu_regfile_sb #(.XLEN(32), .RFREG_NUM(32), .RFIDX_WIDTH(5), .BYPASS(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .bus(b0)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_rd(int b, logic [4:0] idx);
        if (idx == 0) return 32'h0;
        if (b == 1 && w1 && i1 == idx) return d1;
        if (b == 1 && w0 && i0 == idx) return d0;
        return m_rf[idx];
    endfunction

    function automatic bit m_busy(int b, logic [4:0] idx);
        return idx != 0 && m_bsy[b][idx] && !(b == 1 && ((w0 && i0 == idx) || (w1 && i1 == idx)));
    endfunction

    function automatic bit m_rdy(int b);
        return !(rs1en && m_busy(b, s1)) && !(rs2en && m_busy(b, s2)) && !(rdwen && m_busy(b, rd));
    endfunction

    task automatic model_reset();
        foreach (m_rf[k]) m_rf[k] = 32'h0;
        foreach (m_bsy[b, k]) m_bsy[b][k] = 1'b0;
    endtask

    task automatic idle();
        {s1, s2, rd, i0, i1} = '0;
        {d0, d1} = '0;
        {w0, w1, vld, rs1en, rs2en, rdwen} = '0;
    endtask

    // Advance one clock edge, applying the architectural effect of the current inputs to the model
    task automatic tick();
        logic [31:0] nrf [32];
        bit          nb [2][32];
        nrf = m_rf;
        nb  = m_bsy;
        if (w0 && i0 != 0) nrf[i0] = d0;
        if (w1 && i1 != 0) nrf[i1] = d1;
        for (int b = 0; b < 2; b++) begin
            if (w0) nb[b][i0] = 1'b0;
            if (w1) nb[b][i1] = 1'b0;
            if (vld && m_rdy(b) && rdwen && rd != 0) nb[b][rd] = 1'b1;
        end
        @(posedge clk);
        #1;
        m_rf  = nrf;
        m_bsy = nb;
    endtask

    task automatic test_reset();
        idle();
        s1 = 5;
        #1;
        checks++; if (b1.iss_rdy !== 1'b1) begin errors++; $display("FAIL rst_rdy: got %b exp 1", b1.iss_rdy); end
        checks++; if (b1.x1_r !== 32'h0) begin errors++; $display("FAIL rst_x1: got %h exp 0", b1.x1_r); end
        checks++; if (b0.read_src1_dat !== 32'h0) begin errors++; $display("FAIL rst_x5: got %h exp 0", b0.read_src1_dat); end
        w1 = 1; i1 = 5; d1 = 32'h55; w0 = 1; i0 = 1; d0 = 32'h11; vld = 1; rdwen = 1; rd = 6;
        tick();
        idle();
        s1 = 5; s2 = 6;
        #1;
        checks++; if (b1.read_src2_busy !== 1'b1) begin errors++; $display("FAIL pre_busy6: got %b exp 1", b1.read_src2_busy); end
        checks++; if (b0.read_src1_dat !== 32'h55) begin errors++; $display("FAIL pre_x5: got %h exp 55", b0.read_src1_dat); end
        rdwen = 1; rd = 6; rst = 1'b1;
        #1;
        checks++; if (b1.read_src1_dat !== 32'h0) begin errors++; $display("FAIL async_x5: got %h exp 0", b1.read_src1_dat); end
        checks++; if (b0.x1_r !== 32'h0) begin errors++; $display("FAIL async_x1: got %h exp 0", b0.x1_r); end
        checks++; if (b1.read_src2_busy !== 1'b0) begin errors++; $display("FAIL async_busy6: got %b exp 0", b1.read_src2_busy); end
        checks++; if (b0.iss_rdy !== 1'b1) begin errors++; $display("FAIL async_rdy: got %b exp 1", b0.iss_rdy); end
        model_reset();
        idle();
        #2;
        rst = 1'b0;
        tick();
        w1 = 1; i1 = 0; d1 = 32'hDEADBEEF; s1 = 0;
        #1;
        checks++; if (b1.read_src1_dat !== 32'h0) begin errors++; $display("FAIL x0_byp: got %h exp 0", b1.read_src1_dat); end
        checks++; if (b1.read_src1_busy !== 1'b0) begin errors++; $display("FAIL x0_busy: got %b exp 0", b1.read_src1_busy); end
        tick();
        idle();
        #1;
        checks++; if (b1.read_src1_dat !== 32'h0) begin errors++; $display("FAIL x0_read: got %h exp 0", b1.read_src1_dat); end
        checks++; if (b0.read_src1_dat !== 32'h0) begin errors++; $display("FAIL x0_read0: got %h exp 0", b0.read_src1_dat); end
    endtask

    task automatic test_bypass_write();
        idle();
        w0 = 1; i0 = 3; d0 = 32'h12345678; s1 = 3;
        #1;
        checks++; if (b1.read_src1_dat !== 32'h12345678) begin errors++; $display("FAIL byp_same: got %h exp 12345678", b1.read_src1_dat); end
        checks++; if (b1.read_src1_busy !== 1'b0) begin errors++; $display("FAIL byp_busy: got %b exp 0", b1.read_src1_busy); end
        checks++; if (b0.read_src1_dat !== 32'h0) begin errors++; $display("FAIL nobyp_same: got %h exp 0", b0.read_src1_dat); end
        tick();
        idle();
        s1 = 3;
        #1;
        checks++; if (b0.read_src1_dat !== 32'h12345678) begin errors++; $display("FAIL nobyp_next: got %h exp 12345678", b0.read_src1_dat); end
        checks++; if (b1.read_src1_dat !== 32'h12345678) begin errors++; $display("FAIL byp_next: got %h exp 12345678", b1.read_src1_dat); end
    endtask

    task automatic test_dual_conflict();
        idle();
        w0 = 1; i0 = 7; d0 = 32'hAAAA0000; w1 = 1; i1 = 7; d1 = 32'h5555FFFF; s2 = 7;
        #1;
        checks++; if (b1.read_src2_dat !== 32'h5555FFFF) begin errors++; $display("FAIL dual_byp: got %h exp 5555ffff", b1.read_src2_dat); end
        tick();
        idle();
        s2 = 7;
        #1;
        checks++; if (b0.read_src2_dat !== 32'h5555FFFF) begin errors++; $display("FAIL dual_x7_0: got %h exp 5555ffff", b0.read_src2_dat); end
        checks++; if (b1.read_src2_dat !== 32'h5555FFFF) begin errors++; $display("FAIL dual_x7_1: got %h exp 5555ffff", b1.read_src2_dat); end
    endtask

    task automatic test_raw_stall();
        idle();
        vld = 1; rdwen = 1; rd = 9;
        #1;
        checks++; if (b0.iss_rdy !== 1'b1) begin errors++; $display("FAIL raw_issue: got %b exp 1", b0.iss_rdy); end
        tick();
        idle();
        vld = 1; rs1en = 1; s1 = 9;
        #1;
        checks++; if (b1.iss_rdy !== 1'b0) begin errors++; $display("FAIL raw_stall1: got %b exp 0", b1.iss_rdy); end
        checks++; if (b0.iss_rdy !== 1'b0) begin errors++; $display("FAIL raw_stall0: got %b exp 0", b0.iss_rdy); end
        checks++; if (b1.read_src1_busy !== 1'b1) begin errors++; $display("FAIL raw_busy: got %b exp 1", b1.read_src1_busy); end
        tick();
        w0 = 1; i0 = 9; d0 = 32'h42;
        #1;
        checks++; if (b1.iss_rdy !== 1'b1) begin errors++; $display("FAIL raw_wb_rdy1: got %b exp 1", b1.iss_rdy); end
        checks++; if (b0.iss_rdy !== 1'b0) begin errors++; $display("FAIL raw_wb_rdy0: got %b exp 0", b0.iss_rdy); end
        checks++; if (b1.read_src1_dat !== 32'h42) begin errors++; $display("FAIL raw_wb_dat: got %h exp 42", b1.read_src1_dat); end
        tick();
        w0 = 0;
        #1;
        checks++; if (b0.iss_rdy !== 1'b1) begin errors++; $display("FAIL raw_late_rdy0: got %b exp 1", b0.iss_rdy); end
        checks++; if (b0.read_src1_dat !== 32'h42) begin errors++; $display("FAIL raw_late_dat: got %h exp 42", b0.read_src1_dat); end
        tick();
        idle();
    endtask

    task automatic test_waw_collision();
        idle();
        vld = 1; rdwen = 1; rd = 4;
        tick();
        #1;
        checks++; if (b1.iss_rdy !== 1'b0) begin errors++; $display("FAIL waw_stall1: got %b exp 0", b1.iss_rdy); end
        checks++; if (b0.iss_rdy !== 1'b0) begin errors++; $display("FAIL waw_stall0: got %b exp 0", b0.iss_rdy); end
        tick();
        w1 = 1; i1 = 4; d1 = 32'h44;
        #1;
        checks++; if (b1.iss_rdy !== 1'b1) begin errors++; $display("FAIL waw_clr_rdy1: got %b exp 1", b1.iss_rdy); end
        checks++; if (b0.iss_rdy !== 1'b0) begin errors++; $display("FAIL waw_clr_rdy0: got %b exp 0", b0.iss_rdy); end
        tick();
        idle();
        s1 = 4;
        #1;
        checks++; if (b1.read_src1_busy !== 1'b1) begin errors++; $display("FAIL waw_set_wins: got %b exp 1", b1.read_src1_busy); end
        checks++; if (b0.read_src1_busy !== 1'b0) begin errors++; $display("FAIL waw_cleared0: got %b exp 0", b0.read_src1_busy); end
        w0 = 1; i0 = 4; d0 = 32'h45;
        tick();
        idle();
    endtask

    task automatic test_link();
        idle();
        w1 = 1; i1 = 1; d1 = 32'h80000100; s1 = 1;
        #1;
        checks++; if (b1.x1_r !== 32'h0) begin errors++; $display("FAIL x1_early: got %h exp 0", b1.x1_r); end
        checks++; if (b1.read_src1_dat !== 32'h80000100) begin errors++; $display("FAIL x1_byp_read: got %h exp 80000100", b1.read_src1_dat); end
        tick();
        idle();
        #1;
        checks++; if (b1.x1_r !== 32'h80000100) begin errors++; $display("FAIL x1_late1: got %h exp 80000100", b1.x1_r); end
        checks++; if (b0.x1_r !== 32'h80000100) begin errors++; $display("FAIL x1_late0: got %h exp 80000100", b0.x1_r); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            s1 = 5'($urandom_range(0, 31)); s2 = 5'($urandom_range(0, 31)); rd = 5'($urandom_range(0, 31));
            i0 = 5'($urandom_range(0, 31)); i1 = ($urandom_range(0, 3) == 0) ? i0 : 5'($urandom_range(0, 31));
            d0 = $urandom; d1 = $urandom;
            w0 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
            vld = ($urandom_range(0, 9) < 7); rdwen = 1'($urandom_range(0, 1));
            rs1en = 1'($urandom_range(0, 1)); rs2en = 1'($urandom_range(0, 1));
            #1;
            checks++; if (b1.read_src1_dat !== m_rd(1, s1)) begin errors++; $display("FAIL rnd1_src1: cyc %0d got %h exp %h", n, b1.read_src1_dat, m_rd(1, s1)); end
            checks++; if (b1.read_src2_dat !== m_rd(1, s2)) begin errors++; $display("FAIL rnd1_src2: cyc %0d got %h exp %h", n, b1.read_src2_dat, m_rd(1, s2)); end
            checks++; if (b1.read_src1_busy !== m_busy(1, s1)) begin errors++; $display("FAIL rnd1_busy1: cyc %0d got %b exp %b", n, b1.read_src1_busy, m_busy(1, s1)); end
            checks++; if (b1.read_src2_busy !== m_busy(1, s2)) begin errors++; $display("FAIL rnd1_busy2: cyc %0d got %b exp %b", n, b1.read_src2_busy, m_busy(1, s2)); end
            checks++; if (b1.iss_rdy !== m_rdy(1)) begin errors++; $display("FAIL rnd1_rdy: cyc %0d got %b exp %b", n, b1.iss_rdy, m_rdy(1)); end
            checks++; if (b1.x1_r !== m_rf[1]) begin errors++; $display("FAIL rnd1_x1: cyc %0d got %h exp %h", n, b1.x1_r, m_rf[1]); end
            checks++; if (b0.read_src1_dat !== m_rd(0, s1)) begin errors++; $display("FAIL rnd0_src1: cyc %0d got %h exp %h", n, b0.read_src1_dat, m_rd(0, s1)); end
            checks++; if (b0.read_src2_dat !== m_rd(0, s2)) begin errors++; $display("FAIL rnd0_src2: cyc %0d got %h exp %h", n, b0.read_src2_dat, m_rd(0, s2)); end
            checks++; if (b0.read_src1_busy !== m_busy(0, s1)) begin errors++; $display("FAIL rnd0_busy1: cyc %0d got %b exp %b", n, b0.read_src1_busy, m_busy(0, s1)); end
            checks++; if (b0.read_src2_busy !== m_busy(0, s2)) begin errors++; $display("FAIL rnd0_busy2: cyc %0d got %b exp %b", n, b0.read_src2_busy, m_busy(0, s2)); end
            checks++; if (b0.iss_rdy !== m_rdy(0)) begin errors++; $display("FAIL rnd0_rdy: cyc %0d got %b exp %b", n, b0.iss_rdy, m_rdy(0)); end
            checks++; if (b0.x1_r !== m_rf[1]) begin errors++; $display("FAIL rnd0_x1: cyc %0d got %h exp %h", n, b0.x1_r, m_rf[1]); end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_bypass_write();
        test_dual_conflict();
        test_raw_stall();
        test_waw_collision();
        test_link();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
